// File: rtl/bin_to_digits_if.sv
// Start/value request and BCD digit result bundle for bin_to_digits.
// The master drives start/bin; the slave (converter) drives status and digits.
interface bin_to_digits_if #(
  parameter int W = 27
);
  logic         start;
  logic [W-1:0] bin;
  logic         busy;
  logic         done;
  logic         ovf;
  logic [3:0]   dig7;
  logic [3:0]   dig6;
  logic [3:0]   dig5;
  logic [3:0]   dig4;
  logic [3:0]   dig3;
  logic [3:0]   dig2;
  logic [3:0]   dig1;
  logic [3:0]   dig0;

  modport master (
    output start, bin,
    input  busy, done, ovf,
    input  dig7, dig6, dig5, dig4, dig3, dig2, dig1, dig0
  );

  modport slave (
    input  start, bin,
    output busy, done, ovf,
    output dig7, dig6, dig5, dig4, dig3, dig2, dig1, dig0
  );
endinterface

// File: rtl/bin_to_digits.sv
// Serial double-dabble binary-to-BCD converter, one input bit per clock, W+1 cycles per result.
// Optional macro BCD_OVERFLOW_CLAMP_EN: values above 99,999,999 display as all 9s with ovf set.
//
// state | meaning
// IDLE  | waiting for start; digits hold the last result
// SHIFT | add-3 correction then shift one input bit into the BCD scratch
// LOAD  | publish scratch to the digit registers and pulse done
module bin_to_digits #(
  parameter int W = 27
) (
  input  logic            clk,
  input  logic            rst,
  bin_to_digits_if.slave  io
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  shift_q, shift_d;
  logic [31:0]   scratch_q, scratch_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   dig_q, dig_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [31:0]   adj;

`ifdef BCD_OVERFLOW_CLAMP_EN
  localparam logic [31:0] MAX_DEC = 32'd99_999_999;
  logic flag_q, flag_d;
  logic ovf_q, ovf_d;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      dig_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef BCD_OVERFLOW_CLAMP_EN
      flag_q    <= 1'b0;
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      dig_q     <= dig_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef BCD_OVERFLOW_CLAMP_EN
      flag_q    <= flag_d;
      ovf_q     <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (io.start) state_d = SHIFT;
      SHIFT:   if (cnt_q == CW'(1)) state_d = LOAD;
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Add-3 correction is applied to the current scratch before this cycle's shift.
  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < 8; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    dig_d     = dig_q;
    busy_d    = (state_d != IDLE);
    done_d    = (state_q == LOAD);
`ifdef BCD_OVERFLOW_CLAMP_EN
    flag_d    = flag_q;
    ovf_d     = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (io.start) begin
          shift_d   = io.bin;
          scratch_d = '0;
          cnt_d     = CW'(W);
`ifdef BCD_OVERFLOW_CLAMP_EN
          flag_d    = ({{(32 - W){1'b0}}, io.bin} > MAX_DEC);
`endif
        end
      end
      SHIFT: begin
        {scratch_d, shift_d} = {adj, shift_q} << 1;
        cnt_d                = cnt_q - CW'(1);
      end
      LOAD: begin
`ifdef BCD_OVERFLOW_CLAMP_EN
        if (flag_q) begin
          dig_d = 32'h9999_9999;
          ovf_d = 1'b1;
        end else begin
          dig_d = scratch_q;
          ovf_d = 1'b0;
        end
`else
        dig_d = scratch_q;
`endif
      end
      default: ;
    endcase
  end

  assign io.busy = busy_q;
  assign io.done = done_q;
  assign io.dig7 = dig_q[31:28];
  assign io.dig6 = dig_q[27:24];
  assign io.dig5 = dig_q[23:20];
  assign io.dig4 = dig_q[19:16];
  assign io.dig3 = dig_q[15:12];
  assign io.dig2 = dig_q[11:8];
  assign io.dig1 = dig_q[7:4];
  assign io.dig0 = dig_q[3:0];
`ifdef BCD_OVERFLOW_CLAMP_EN
  assign io.ovf  = ovf_q;
`else
  assign io.ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_bin_to_digits.sv
// Scoreboard bench for bin_to_digits: decimal reference model, queue of expected results,
// monitor checks digits, ovf, done cycle and busy length whenever done pulses.
module tb_bin_to_digits;
  localparam int W = 27;

  typedef struct {
    logic [31:0] dig;
    logic        ovf;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  bin_to_digits_if #(.W(W)) bi ();
  bin_to_digits #(.W(W)) dut (.clk(clk), .rst(rst), .io(bi.slave));

  logic [31:0] act_dig;
  assign act_dig = {bi.dig7, bi.dig6, bi.dig5, bi.dig4, bi.dig3, bi.dig2, bi.dig1, bi.dig0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Decimal reference: digits of value mod 1e8, or all 9s when clamping is built in.
  function automatic logic [32:0] ref_model(input longint unsigned v);
    logic [31:0] d;
    longint unsigned m;
    d = '0;
`ifdef BCD_OVERFLOW_CLAMP_EN
    if (v > 64'd99_999_999) return {1'b1, 32'h9999_9999};
`endif
    m = v % 64'd100_000_000;
    for (int i = 0; i < 8; i++) begin
      d[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return {1'b0, d};
  endfunction

  // Caller sits at a negedge; start is accepted at the following posedge.
  task automatic conv(input logic [W-1:0] v, input bit expect_it);
    exp_t e;
    logic [32:0] r;
    bi.start = 1'b1;
    bi.bin   = v;
    if (expect_it) begin
      r     = ref_model(64'(v));
      e.dig = r[31:0];
      e.ovf = r[32];
      e.cyc = cyc + 1 + W + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    bi.start = 1'b0;
    bi.bin   = W'($urandom);
  endtask

  // Monitor
  int busy_run = 0;
  logic busy_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (bi.done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("digits", 64'(act_dig), 64'(e.dig));
        chk("ovf", 64'(bi.ovf), 64'(e.ovf));
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    if (busy_prev && !bi.busy && bi.done) chk("busy_len", 64'(busy_run), 64'(W + 1));
    busy_run  = bi.busy ? busy_run + 1 : 0;
    busy_prev = bi.busy;
  end

  initial begin
    logic [W-1:0] v;
    rst      = 1'b0;
    bi.start = 1'b0;
    bi.bin   = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(bi.busy), 64'd0);
    chk("rst_done", 64'(bi.done), 64'd0);
    chk("rst_ovf", 64'(bi.ovf), 64'd0);
    chk("rst_digits", 64'(act_dig), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    conv(W'(12_345_678), 1'b1);
    repeat (W + 3) @(negedge clk);
    conv(W'(0), 1'b1);
    repeat (W + 3) @(negedge clk);
    conv(W'(99_999_999), 1'b1);
    repeat (W + 3) @(negedge clk);
    conv(W'(134_217_727), 1'b1);
    repeat (W + 3) @(negedge clk);
    conv(W'(5), 1'b1);
    repeat (W + 3) @(negedge clk);

    // start while busy is dropped, not queued
    conv(W'(42), 1'b1);
    repeat (8) @(negedge clk);
    conv(W'(7), 1'b0);
    repeat (W + 8) @(negedge clk);

    // back-to-back: restart in each done cycle
    conv(W'(1), 1'b1);
    repeat (W + 1) @(negedge clk);
    conv(W'(2), 1'b1);
    repeat (W + 1) @(negedge clk);
    repeat (3) @(negedge clk);

    // reset mid-conversion aborts with no done
    conv(W'(77_777_777), 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_busy", 64'(bi.busy), 64'd0);
    chk("abort_done", 64'(bi.done), 64'd0);
    chk("abort_ovf", 64'(bi.ovf), 64'd0);
    chk("abort_digits", 64'(act_dig), 64'd0);
    rst = 1'b1;
    repeat (W + 10) @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      v = W'($urandom);
      if (i % 4 == 0) v = W'(99_999_990 + $urandom_range(0, 20));
      conv(v, 1'b1);
      repeat (W + 1 + $urandom_range(0, 3)) @(negedge clk);
    end

    repeat (W + 5) @(negedge clk);
    chk("queue_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bin_to_digits.md
# bin_to_digits

Sequential binary-to-BCD converter that drives the eight 4-bit digit inputs of the multiplexed seven-segment display interface. It accepts an unsigned binary value on a start strobe and runs a serial double-dabble (shift-and-add-3) conversion, one input bit per clock. On completion it updates eight registered BCD digit outputs and pulses `done`. Digits hold steady between conversions, so the display never shows partial results.

## Interface
- `W`, default 27: input width, legal range 1..27. 27 bits covers 99,999,999.
- `clk` input 1: system clock; all logic is on the rising edge.
- `rst` input 1: synchronous, active-low reset.
- `start` input 1: conversion request, sampled on the rising edge.
- `bin` input W: unsigned value; sampled only on the edge where `start` is accepted.
- `busy` output 1: high while a conversion is in progress.
- `done` output 1: one-cycle pulse; the digit outputs are valid from the same cycle.
- `ovf` output 1: input exceeded 99,999,999 (see Configuration).
- `dig7`..`dig0` output 4 each: BCD digits, most significant to least significant, feeding the display digit inputs of the same names.

## Operation
- FSM states:
  - IDLE: waits for `start`.
    - `start`=1 latches `bin` into the shift register, clears the 32-bit BCD scratch register, loads bit counter = W, and moves to SHIFT.
  - SHIFT: once per cycle:
    - Every scratch nibble ≥5 gets +3 (combinational).
    - {scratch, shift} then shifts left by 1, so the shift-register MSB enters scratch bit 0.
    - The counter decrements. After the W-th shift, the FSM moves to LOAD.
  - LOAD: copies scratch[31:0] to {`dig7`..`dig0`}, sets `done`=1, returns to IDLE.
- Bits shifted out of scratch[31] are discarded. Without the overflow feature, the digits equal `bin` mod 10^8.
- `start` in SHIFT or LOAD is ignored; it is not queued.
- `bin` changes after acceptance have no effect.
- `dig*` and `ovf` change only in LOAD; they hold their value otherwise.

## Timing
- Reset (`rst`=0 at an edge) forces state IDLE and clears the shift register, scratch and counter. It also sets `busy`=0, `done`=0, `ovf`=0 and all `dig*`=4'h0.
- Reset mid-conversion aborts the conversion with no `done`.
- `start` accepted at edge k:
  - `busy`=1 from after edge k.
  - SHIFT occupies edges k+1..k+W.
  - LOAD at edge k+W+1 updates the digits, sets `done`=1 and sets `busy`=0.
  - Latency from the accepting edge to `done` is W+1 cycles (28 at the default).
- `done` is high for exactly one cycle. It is registered and deasserts on the next edge.
- `start` asserted in the `done` cycle is accepted, because the FSM is in IDLE. Sustained throughput is one conversion per W+1 cycles.
- `busy` is registered and equals (state ≠ IDLE).

## Configuration
- Macro: `BCD_OVERFLOW_CLAMP_EN`.
- Defined:
  - On acceptance, the block registers the flag (`bin` > 99,999,999). This is only possible when W ≥ 27.
  - In LOAD with the flag set, all `dig*`=4'h9 and `ovf`=1.
  - Otherwise LOAD writes the converted digits and `ovf`=0.
  - `ovf` holds until the next LOAD or reset.
- Undefined:
  - No comparator is built and `ovf` is tied to 0.
  - Oversize values display as value mod 10^8.

## Test plan
- Reset: hold `rst`=0 for 2 cycles mid-conversion, then release. Required: `busy`=0, `done`=0, `ovf`=0, all digits 0, no `done` pulse afterwards.
- Mid-range value: `bin`=12,345,678 with a 1-cycle `start`. Required: `done` exactly 28 cycles after the accepting edge, with `dig7`..`dig0`=1,2,3,4,5,6,7,8 and `busy` high for exactly 28 cycles.
- Edge values: `bin`=0, then 99,999,999. Required: all digits 0, then all digits 9, with `ovf`=0 in both cases.
- Overflow: `bin`=134,217,727.
  - Without the macro: digits 3,4,2,1,7,7,2,7 and `ovf`=0.
  - With `BCD_OVERFLOW_CLAMP_EN`: all digits 9 and `ovf`=1.
  - A following conversion of 5 gives `ovf`=0 and digits 0000_0005.
- Start while busy: `start` with `bin`=42, then `start` with `bin`=7 at cycle 10. Required: a single `done`, result 0000_0042.
- Back-to-back: re-assert `start` (`bin`=1, then 2) in each `done` cycle. Required: `done` pulses spaced exactly 28 cycles apart, with results 1 then 2.
